// File: rtl/mem_stage_pkg.sv
// Shared widths and bundle layouts for the memory stage.
// Execute and writeback use the same field orders.
package mem_stage_pkg;

  localparam int EX_TO_MEM_DATA_WIDTH  = 79;
  localparam int EX_TO_MEM_EXCEP_WIDTH = 87;
  localparam int MEM_TO_WB_DATA_WIDTH  = 70;
  localparam int MEM_TO_WB_EXCEP_WIDTH = 119;
  localparam int MEM_RF_ZIP_WIDTH      = 40;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic [31:0] ex_result;
    logic        ld_b;
    logic        ld_bu;
    logic        ld_h;
    logic        ld_hu;
    logic        ld_w;
    logic        mem_req;
    logic        res_from_mul;
    logic        mul_h;
    logic        res_from_div;
  } ex_mem_t;

  typedef struct packed {
    logic        res_from_csr;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        has_int;
    logic        adef;
    logic        syscall;
    logic        brk;
    logic        ale;
    logic        ine;
  } excep_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
    logic [31:0] final_result;
  } mem_wb_t;

  function automatic logic any_excep(excep_t e);
    return e.ertn | e.has_int | e.adef | e.syscall
         | e.brk | e.ale | e.ine;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks buffered or live response,
// then selects and extends the byte/half/word.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic        rbuf_valid,
  input  logic [31:0] rbuf,
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic        ld_b,
  input  logic        ld_bu,
  input  logic        ld_h,
  input  logic        ld_hu,
  input  logic        ld_w,
  output logic [31:0] value
);

  logic [31:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    word   = rbuf_valid ? rbuf : rdata;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    value  = word;
    unique case (1'b1)
      ld_b:    value = {{24{byte_v[7]}}, byte_v};
      ld_bu:   value = {24'd0, byte_v};
      ld_h:    value = {{16{half_v[15]}}, half_v};
      ld_hu:   value = {16'd0, half_v};
      ld_w:    value = word;
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: completes SRAM responses, buffers them
// across writeback stalls and absorbs responses of flushed ops.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                             clk,
  input  logic                             resetn,
  output logic                             mem_allowin,
  input  logic                             ex_to_mem_valid,
  input  logic [EX_TO_MEM_DATA_WIDTH-1:0]  ex_to_mem_data,
  input  logic [EX_TO_MEM_EXCEP_WIDTH-1:0] ex_to_mem_excep,
  input  logic [63:0]                      mul_result,
  input  logic                             data_sram_data_ok,
  input  logic [31:0]                      data_sram_rdata,
  input  logic                             wb_allowin,
  output logic                             mem_to_wb_valid,
  output logic [MEM_TO_WB_DATA_WIDTH-1:0]  mem_to_wb_data,
  output logic [MEM_TO_WB_EXCEP_WIDTH-1:0] mem_to_wb_excep,
  output logic [MEM_RF_ZIP_WIDTH-1:0]      mem_rf_zip,
  output logic                             mem_to_ex_excep,
  input  logic                             mem_flush
);

  logic        mem_valid;
  ex_mem_t     data_reg;
  excep_t      excep_reg;
  logic        rbuf_valid;
  logic [31:0] rbuf;
  logic [1:0]  discard_cnt;

  logic        drop;
  logic        got_resp;
  logic        ready_go;
  logic        advance;
  logic        take;
  logic        pend;
  logic        inc;
  logic        is_load;
  logic        load_block;
  logic [31:0] ld_data;
  logic [31:0] final_result;
  mem_wb_t     wb_bus;
  logic        unused_div;

  assign drop     = data_sram_data_ok & (discard_cnt != 2'd0);
  assign got_resp = rbuf_valid
                  | (data_sram_data_ok & (discard_cnt == 2'd0));
  assign ready_go = ~data_reg.mem_req | got_resp;

  assign mem_allowin = ~mem_valid
                     | (ready_go & wb_allowin)
                     | mem_flush;
  assign mem_to_wb_valid = mem_valid & ready_go & ~mem_flush;
  assign advance = mem_to_wb_valid & wb_allowin;

  assign take = data_sram_data_ok & ~drop & mem_valid
              & data_reg.mem_req & ~rbuf_valid;
  assign pend = mem_valid & data_reg.mem_req & ~got_resp;
  assign inc  = mem_flush & pend;

  assign is_load = data_reg.ld_b | data_reg.ld_bu | data_reg.ld_h
                 | data_reg.ld_hu | data_reg.ld_w;

  mem_load_align u_align (
    .rbuf_valid (rbuf_valid),
    .rbuf       (rbuf),
    .rdata      (data_sram_rdata),
    .off        (data_reg.ex_result[1:0]),
    .ld_b       (data_reg.ld_b),
    .ld_bu      (data_reg.ld_bu),
    .ld_h       (data_reg.ld_h),
    .ld_hu      (data_reg.ld_hu),
    .ld_w       (data_reg.ld_w),
    .value      (ld_data)
  );

  always_comb begin
    final_result = data_reg.ex_result;
    unique case (1'b1)
      is_load:               final_result = ld_data;
      data_reg.res_from_mul: final_result = data_reg.mul_h
                                          ? mul_result[63:32]
                                          : mul_result[31:0];
      default:               final_result = data_reg.ex_result;
    endcase
  end

  // mul counts as blocking so EX never forwards a half-ready product
  assign load_block = mem_valid
                    & (is_load | data_reg.res_from_mul)
                    & ~ready_go;

  assign wb_bus.rf_we        = data_reg.rf_we;
  assign wb_bus.rf_waddr     = data_reg.rf_waddr;
  assign wb_bus.pc           = data_reg.pc;
  assign wb_bus.final_result = final_result;

  assign mem_to_wb_data  = wb_bus;
  assign mem_to_wb_excep = {excep_reg, data_reg.ex_result};
  assign mem_rf_zip      = {excep_reg.res_from_csr, load_block,
                            data_reg.rf_we & mem_valid,
                            data_reg.rf_waddr, final_result};
  assign mem_to_ex_excep = mem_valid & any_excep(excep_reg);
  assign unused_div      = data_reg.res_from_div;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid   <= 1'b0;
      rbuf_valid  <= 1'b0;
      discard_cnt <= 2'd0;
    end else begin
      if (mem_flush)
        mem_valid <= 1'b0;
      else if (mem_allowin)
        mem_valid <= ex_to_mem_valid;

      if (mem_flush | advance)
        rbuf_valid <= 1'b0;
      else if (take)
        rbuf_valid <= 1'b1;

      if (inc & ~drop) begin
        if (discard_cnt != 2'd3)
          discard_cnt <= discard_cnt + 2'd1;
      end else if (drop & ~inc) begin
        discard_cnt <= discard_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ex_to_mem_valid & mem_allowin) begin
      data_reg  <= ex_to_mem_data;
      excep_reg <= ex_to_mem_excep;
    end
    if (take & ~advance)
      rbuf <= data_sram_rdata;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage with a transaction-level
// model of load extension, mul select and flush discards.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         mem_allowin;
  logic         ex_to_mem_valid = 1'b0;
  logic [78:0]  ex_to_mem_data = '0;
  logic [86:0]  ex_to_mem_excep = '0;
  logic [63:0]  mul_result = '0;
  logic         data_sram_data_ok = 1'b0;
  logic [31:0]  data_sram_rdata = '0;
  logic         wb_allowin = 1'b0;
  logic         mem_to_wb_valid;
  logic [69:0]  mem_to_wb_data;
  logic [118:0] mem_to_wb_excep;
  logic [39:0]  mem_rf_zip;
  logic         mem_to_ex_excep;
  logic         mem_flush = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int stale   = 0;
  logic [31:0] last_res = '0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_allowin       (mem_allowin),
    .ex_to_mem_valid   (ex_to_mem_valid),
    .ex_to_mem_data    (ex_to_mem_data),
    .ex_to_mem_excep   (ex_to_mem_excep),
    .mul_result        (mul_result),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_data    (mem_to_wb_data),
    .mem_to_wb_excep   (mem_to_wb_excep),
    .mem_rf_zip        (mem_rf_zip),
    .mem_to_ex_excep   (mem_to_ex_excep),
    .mem_flush         (mem_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // kinds: 0 alu, 1 mul, 2 ld.b, 3 ld.bu, 4 ld.h, 5 ld.hu, 6 ld.w, 7 store
  function automatic logic [31:0] model(input int kind,
                                        input logic [31:0] addr,
                                        input logic [31:0] rdata,
                                        input logic [63:0] mul,
                                        input bit mulh);
    int off;
    int b;
    int h;
    off = int'(addr % 4);
    b = int'((rdata >> (8 * off)) & 32'hFF);
    h = int'((rdata >> (16 * (off / 2))) & 32'hFFFF);
    case (kind)
      1: return mulh ? mul[63:32] : mul[31:0];
      2: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3: return 32'(b);
      4: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      5: return 32'(h);
      6: return rdata;
      default: return addr;
    endcase
  endfunction

  task automatic check_out(input logic [31:0] exp_r,
                           input logic rf_we,
                           input logic [4:0] wa,
                           input logic [31:0] pc,
                           input logic [86:0] e);
    chk("wb_valid", mem_to_wb_valid, 1);
    chk("wb_data", mem_to_wb_data, {rf_we, wa, pc, exp_r});
    chk("rf_zip", mem_rf_zip, {e[86], 1'b0, rf_we, wa, exp_r});
    last_res = mem_to_wb_data[31:0];
  endtask

  task automatic run_op(input int kind,
                        input logic [31:0] addr,
                        input logic [31:0] rdata,
                        input logic [63:0] mul,
                        input bit mulh,
                        input int dly,
                        input int stall,
                        input bit flush);
    logic [86:0] e;
    logic        rf_we;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic [31:0] exp_r;
    bit          is_mem;
    bit          is_ld;
    is_mem = (kind >= 2);
    is_ld  = (kind >= 2) && (kind <= 6);
    rf_we  = 1'($urandom);
    wa     = 5'($urandom);
    pc     = $urandom;
    e      = {23'($urandom), $urandom, $urandom};
    if ($urandom_range(0, 1) == 0) e[6:0] = '0;
    exp_r  = model(kind, addr, rdata, mul, mulh);

    ex_to_mem_valid   = 1'b1;
    ex_to_mem_data    = {rf_we, wa, pc, addr, kind == 2, kind == 3,
                         kind == 4, kind == 5, kind == 6, is_mem,
                         kind == 1, mulh, 1'b0};
    ex_to_mem_excep   = e;
    wb_allowin        = 1'b0;
    data_sram_data_ok = 1'b0;
    settle;
    chk("drained", mem_to_wb_valid, 0);
    chk("allowin_idle", mem_allowin, 1);
    tick;
    ex_to_mem_valid = 1'b0;
    mul_result      = mul;
    settle;
    chk("excep_flag", mem_to_ex_excep, |e[6:0]);
    chk("excep_pass", mem_to_wb_excep, {e, addr});

    if (is_mem) begin
      while (stale > 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        settle;
        chk("stale_hold", mem_to_wb_valid, 0);
        chk("stale_cnt", dut.discard_cnt, stale);
        tick;
        stale--;
      end
      data_sram_data_ok = 1'b0;
      for (int i = 0; i < dly; i++) begin
        data_sram_rdata = $urandom;
        settle;
        chk("wait_valid", mem_to_wb_valid, 0);
        chk("wait_block", mem_rf_zip[38], is_ld);
        tick;
      end
    end

    if (flush) begin
      mem_flush = 1'b1;
      settle;
      chk("flush_valid", mem_to_wb_valid, 0);
      chk("flush_allowin", mem_allowin, 1);
      tick;
      mem_flush = 1'b0;
      if (is_mem) stale++;
      settle;
      chk("flush_cnt", dut.discard_cnt, stale);
      chk("flush_empty", mem_to_ex_excep, 0);
      return;
    end

    if (is_mem) begin
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      wb_allowin        = (stall == 0);
      settle;
      check_out(exp_r, rf_we, wa, pc, e);
      if (stall > 0) begin
        chk("resp_allowin", mem_allowin, 0);
        tick;
        data_sram_data_ok = 1'b0;
        for (int i = 1; i < stall; i++) begin
          data_sram_rdata = $urandom;
          settle;
          chk("buf_valid", mem_to_wb_valid, 1);
          chk("buf_allowin", mem_allowin, 0);
          tick;
        end
        data_sram_rdata = ~rdata;
        wb_allowin      = 1'b1;
        settle;
        chk("rbuf_set", dut.rbuf_valid, 1);
        check_out(exp_r, rf_we, wa, pc, e);
        tick;
        settle;
        chk("rbuf_clr", dut.rbuf_valid, 0);
      end else begin
        tick;
      end
      data_sram_data_ok = 1'b0;
    end else begin
      for (int i = 0; i < stall; i++) begin
        settle;
        chk("alu_valid", mem_to_wb_valid, 1);
        chk("alu_allowin", mem_allowin, 0);
        tick;
      end
      wb_allowin = 1'b1;
      settle;
      check_out(exp_r, rf_we, wa, pc, e);
      tick;
    end
    wb_allowin = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    tick;
    tick;
    chk("rst_allowin", mem_allowin, 1);
    chk("rst_valid", mem_to_wb_valid, 0);
    chk("rst_excep", mem_to_ex_excep, 0);
    chk("rst_block", mem_rf_zip[38], 0);
    chk("rst_discard", dut.discard_cnt, 0);
    resetn = 1'b1;
    tick;

    run_op(6, 32'h1000, 32'hDEAD_BEEF, 64'd0, 0, 0, 0, 0);
    chk("plan_ldw", last_res, 32'hDEAD_BEEF);
    run_op(2, 32'h1003, 32'h80FF_0000, 64'd0, 0, 1, 0, 0);
    chk("plan_ldb", last_res, 32'hFFFF_FF80);
    run_op(3, 32'h1003, 32'h80FF_0000, 64'd0, 0, 0, 0, 0);
    chk("plan_ldbu", last_res, 32'h0000_0080);
    run_op(4, 32'h1002, 32'h80FF_0000, 64'd0, 0, 0, 0, 0);
    chk("plan_ldh", last_res, 32'hFFFF_80FF);
    run_op(5, 32'h1002, 32'h80FF_0000, 64'd0, 0, 2, 0, 0);
    chk("plan_ldhu", last_res, 32'h0000_80FF);
    run_op(6, 32'h2000, 32'hCAFE_F00D, 64'd0, 0, 0, 2, 0);
    chk("plan_rbuf", last_res, 32'hCAFE_F00D);
    run_op(6, 32'h3000, 32'h0, 64'd0, 0, 1, 0, 1);
    chk("plan_stale", stale, 1);
    run_op(6, 32'h3004, 32'h2222_2222, 64'd0, 0, 0, 0, 0);
    chk("plan_fresh", last_res, 32'h2222_2222);
    run_op(1, 32'h4000, 32'h0, 64'h0000_0001_FFFF_FFFE, 1, 0, 0, 0);
    chk("plan_mulh", last_res, 32'h0000_0001);
    run_op(7, 32'h5004, 32'h0, 64'd0, 0, 1, 1, 0);
    chk("plan_store", last_res, 32'h0000_5004);

    for (int n = 0; n < 400; n++) begin
      run_op($urandom_range(0, 7), $urandom, $urandom,
             {$urandom, $urandom}, 1'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 5) == 0);
      chk("discard_sat", dut.discard_cnt == 2'd3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline, between the execute stage and writeback. It receives the execute bundle plus the exception bundle and completes data-SRAM responses. It also aligns and extends load data, selects the multiplier half, and drives the writeback bundle. It publishes a forwarding/hazard bus and an exception-present flag. Outstanding responses that belong to flushed instructions are absorbed, so they never reach a later load.

## Interface
Parameters: none; widths come from the shared header (`EX_TO_MEM_DATA_WIDTH`=79, `EX_TO_MEM_EXCEP_WIDTH`=87, `MEM_TO_WB_DATA_WIDTH`=70, `MEM_TO_WB_EXCEP_WIDTH`=119).
- clk  in  1  single clock
- resetn  in  1  synchronous, active-low reset
- mem_allowin  out  1  stage can accept an execute bundle this cycle
- ex_to_mem_valid  in  1  execute bundle valid
- ex_to_mem_data  in  79  {rf_we, rf_waddr[4:0], pc[31:0], ex_result[31:0], ld_b, ld_bu, ld_h, ld_hu, ld_w, mem_req, res_from_mul, mul_h, res_from_div}
- ex_to_mem_excep  in  87  {res_from_csr, csr_num[13:0], csr_we, csr_wmask[31:0], csr_wvalue[31:0], ertn, has_int, adef, syscall, brk, ale, ine}
- mul_result  in  64  product of the multiply issued last cycle
- data_sram_data_ok  in  1  response valid, one per accepted request, in order
- data_sram_rdata  in  32  response data
- wb_allowin  in  1  writeback can accept
- mem_to_wb_valid  out  1  writeback bundle valid
- mem_to_wb_data  out  70  {rf_we, rf_waddr, pc, final_result}
- mem_to_wb_excep  out  119  {excep bundle as received, vaddr[31:0]}; vaddr = ex_result
- mem_rf_zip  out  40  {res_from_csr, load_block, rf_we&valid, rf_waddr, final_result}
- mem_to_ex_excep  out  1  valid instruction in this stage carries any exception bit or ertn
- mem_flush  in  1  exception/ertn flush from writeback

## Operation
- Registers: mem_valid; data_reg and excep_reg, both loaded when ex_to_mem_valid & mem_allowin; rbuf_valid and rbuf[31:0] hold a response that arrives while writeback stalls; discard_cnt[1:0].
- Response consumption: data_ok with discard_cnt≠0 decrements discard_cnt and is dropped. Otherwise, if mem_valid & mem_req & ~rbuf_valid, the response belongs to the current load or store. It is latched into rbuf when the stage does not advance that cycle.
- got_resp = rbuf_valid | (data_ok & discard_cnt==0).
- ready_go = ~mem_req | got_resp.
- mem_allowin = ~mem_valid | (ready_go & wb_allowin) | mem_flush.
- mem_to_wb_valid = mem_valid & ready_go & ~mem_flush.
- Load data: the sub-module selects from rbuf when rbuf_valid, else from data_sram_rdata. Byte = rdata[8*off +: 8], off = ex_result[1:0]. Half = rdata[16*off[1] +: 16]. ld_b and ld_h sign-extend; ld_bu and ld_hu zero-extend; ld_w passes the word unchanged.
- final_result priority: any load → aligned data. Else res_from_mul → mul_h ? mul_result[63:32] : mul_result[31:0]. Else ex_result.
- load_block = mem_valid & (load | res_from_mul) & ~ready_go. res_from_mul makes the hazard conservative.
- Flush: mem_valid is cleared on the next edge. If mem_valid & mem_req & ~got_resp at flush, discard_cnt increments; a simultaneous dropped data_ok cancels that increment. Flush also clears rbuf_valid.
- discard_cnt saturates at 3. This is unreachable by design; the bench flags it.

## Timing
- Reset: mem_valid=0, rbuf_valid=0, discard_cnt=0. Therefore mem_allowin=1, mem_to_wb_valid=0, mem_to_ex_excep=0, and load_block=0.
- Latency for non-memory instructions is 1 cycle: accepted at edge N, mem_to_wb_valid during cycle N+1 when wb_allowin=1.
- Loads: data_ok may arrive in the first cycle in MEM or later. The stage advances in the same cycle as data_ok when wb_allowin=1; the path from data_ok to the result is combinational.
- Stores wait for data_ok identically; their final_result = ex_result.
- mem_to_ex_excep and mem_rf_zip are combinational from registered state plus data_ok. The execute stage suppresses new requests in the same cycle it sees mem_to_ex_excep.
- Reset mid-load loses the response. The whole pipeline resets together, so this is acceptable.

## Structure
- The shared header holds the width macros and bundle field orders above; the execute stage and writeback use the same definitions.
- Sub-module mem_load_align is purely combinational: (rdata, off, ld_b/bu/h/hu/w) → 32-bit value.
- Everything else lives in mem_stage, including the rbuf, discard counter, and valid/handshake logic.

## Test plan
- ld.w with addr 0x1000, data_ok in the first MEM cycle with rdata 0xDEADBEEF, wb_allowin=1 → mem_to_wb_valid that cycle, final_result 0xDEADBEEF.
- ld.b at off 3 with rdata 0x80FF_0000 → 0xFFFFFF80. ld.bu → 0x00000080. ld.h at off 2 → 0xFFFF80FF. ld.hu → 0x000080FF.
- ld.w data_ok arrives while wb_allowin=0 → rbuf captures it and mem_allowin=0. wb_allowin rises 2 cycles later → mem_to_wb_valid=1 with the buffered data, and rbuf_valid clears.
- Load pending with no data_ok, then mem_flush → mem_to_wb_valid=0, discard_cnt=1. A new ld.w enters, the stale data_ok (0x11111111) is dropped, and the next data_ok (0x22222222) is delivered.
- mul.w.h with mul_h=1 and mul_result 0x0000_0001_FFFF_FFFE → final_result 0x00000001. During the MEM cycle load_block=0 because ready_go=1.
- ertn or ale bit set with mem_valid=1 → mem_to_ex_excep=1 that cycle, and the excep bundle is passed through with vaddr = ex_result.
